// File: rtl/mc_controller.sv
// mc_controller: multi-cycle main control FSM for the RV32I core.
// It sequences the shared ALU, the single valid/ready memory port, IR/PC and the
// register file for R-ALU, I-ALU, LW, SW, BEQ/BNE, JAL and LUI.
// Optional feature macro: RV_ILLEGAL_TRAP_EN (sticky illegal flag + TRAP state).
// ALU and opcode encodings follow rv_defs.v; local fallbacks are defined if absent.

`timescale 1ns/1ps

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`endif

`ifndef opcode_LW
`define opcode_LW     7'b0000011
`define opcode_SW     7'b0100011
`define opcode_RTYPE  7'b0110011
`define opcode_ITYPE  7'b0010011
`define opcode_BRANCH 7'b1100011
`define opcode_JAL    7'b1101111
`define opcode_LUI    7'b0110111
`endif

module mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_valid,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] res_src,
    output logic [3:0] alu_ctrl,
    output logic [2:0] imm_src,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI
`ifdef RV_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    // Registered Moore outputs, loaded with the decode of the next state so they
    // are valid for the whole cycle the FSM spends in that state.
    logic       r_mem_valid;
    logic       r_mem_we;
    logic       r_adr_src;
    logic       r_reg_we;
    logic [1:0] r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [1:0] r_res_src;
    logic [3:0] r_alu_ctrl;
    logic [2:0] r_imm_src;
    logic       r_in_fetch;
    logic       r_in_branch;
    logic       r_in_jal;

    logic       w_mem_valid;
    logic       w_mem_we;
    logic       w_adr_src;
    logic       w_reg_we;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_res_src;
    logic [3:0] w_alu_ctrl;
    logic [2:0] w_imm_src;
    logic       w_in_fetch;
    logic       w_in_branch;
    logic       w_in_jal;
    logic       w_br_take;

`ifdef RV_ILLEGAL_TRAP_EN
    logic       r_illegal;
    logic       w_illegal;
`endif

    // ALU operation for R-type (is_imm=0) and I-type (is_imm=1) arithmetic.
    // For immediates bit 30 belongs to the immediate, so it only selects SRA.
    function automatic logic [3:0] f_alu_dec(input logic [2:0] f3,
                                             input logic       b5,
                                             input logic       is_imm);
        logic [3:0] v;
        case (f3)
            3'b000:  v = (b5 && !is_imm) ? `ALU_SUB : `ALU_ADD;
            3'b001:  v = `ALU_SLL;
            3'b010:  v = `ALU_SLT;
            3'b011:  v = `ALU_SLTU;
            3'b100:  v = `ALU_XOR;
            3'b101:  v = b5 ? `ALU_SRA : `ALU_SRL;
            3'b110:  v = `ALU_OR;
            default: v = `ALU_AND;
        endcase
        return v;
    endfunction

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    `opcode_LW, `opcode_SW: w_next = S_MEMADR;
                    // Only funct7[5] reaches this block, so every R-type funct7
                    // visible here is either 0x00 or 0x20 and is accepted.
                    `opcode_RTYPE: w_next = S_EXECR;
                    `opcode_ITYPE: w_next = S_EXECI;
`ifdef RV_ILLEGAL_TRAP_EN
                    `opcode_BRANCH: w_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
`else
                    `opcode_BRANCH: w_next = S_BRANCH;
`endif
                    `opcode_JAL: w_next = S_JAL;
                    `opcode_LUI: w_next = S_LUI;
`ifdef RV_ILLEGAL_TRAP_EN
                    default: w_next = S_TRAP;
`else
                    default: w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: w_next = (op == `opcode_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_MEMWB:  w_next = S_FETCH;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JAL:    w_next = S_ALUWB;
            S_LUI:    w_next = S_ALUWB;
`ifdef RV_ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode of the state being entered. IR is already latched when
    // DECODE computes these, so funct3/funct7b5/op are stable here.
    always_comb begin
        w_mem_valid = 1'b0;
        w_mem_we    = 1'b0;
        w_adr_src   = 1'b0;
        w_reg_we    = 1'b0;
        w_alu_src_a = 2'b00;
        w_alu_src_b = 2'b00;
        w_res_src   = 2'b00;
        w_alu_ctrl  = `ALU_ADD;
        w_imm_src   = 3'b000;
        w_in_fetch  = 1'b0;
        w_in_branch = 1'b0;
        w_in_jal    = 1'b0;
`ifdef RV_ILLEGAL_TRAP_EN
        w_illegal   = 1'b0;
`endif
        case (w_next)
            S_FETCH: begin
                w_mem_valid = 1'b1;
                w_alu_src_b = 2'b10;
                w_res_src   = 2'b10;
                w_in_fetch  = 1'b1;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_imm_src   = 3'b010;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = (op == `opcode_SW) ? 3'b001 : 3'b000;
            end
            S_MEMRD: begin
                w_mem_valid = 1'b1;
                w_adr_src   = 1'b1;
            end
            S_MEMWR: begin
                w_mem_valid = 1'b1;
                w_mem_we    = 1'b1;
                w_adr_src   = 1'b1;
            end
            S_MEMWB: begin
                w_reg_we    = 1'b1;
                w_res_src   = 2'b01;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_ctrl  = f_alu_dec(funct3, funct7b5, 1'b0);
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_ctrl  = f_alu_dec(funct3, funct7b5, 1'b1);
            end
            S_ALUWB: begin
                w_reg_we    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a = 2'b10;
                w_alu_ctrl  = `ALU_SUB;
                w_in_branch = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_in_jal    = 1'b1;
            end
            S_LUI: begin
                w_alu_src_a = 2'b11;
                w_alu_src_b = 2'b01;
                w_imm_src   = 3'b100;
            end
`ifdef RV_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_illegal   = 1'b1;
            end
`endif
            default: begin
                w_mem_valid = 1'b0;
            end
        endcase
    end

    // State register and registered outputs; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_adr_src   <= 1'b0;
            r_reg_we    <= 1'b0;
            r_alu_src_a <= '0;
            r_alu_src_b <= '0;
            r_res_src   <= '0;
            r_alu_ctrl  <= '0;
            r_imm_src   <= '0;
            r_in_fetch  <= 1'b0;
            r_in_branch <= 1'b0;
            r_in_jal    <= 1'b0;
`ifdef RV_ILLEGAL_TRAP_EN
            r_illegal   <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_mem_valid <= w_mem_valid;
            r_mem_we    <= w_mem_we;
            r_adr_src   <= w_adr_src;
            r_reg_we    <= w_reg_we;
            r_alu_src_a <= w_alu_src_a;
            r_alu_src_b <= w_alu_src_b;
            r_res_src   <= w_res_src;
            r_alu_ctrl  <= w_alu_ctrl;
            r_imm_src   <= w_imm_src;
            r_in_fetch  <= w_in_fetch;
            r_in_branch <= w_in_branch;
            r_in_jal    <= w_in_jal;
`ifdef RV_ILLEGAL_TRAP_EN
            r_illegal   <= w_illegal;
`endif
        end
    end

    // Branch resolution uses the ALU zero flag of the current cycle.
    assign w_br_take = ((funct3 == 3'b000) &&  zero) ||
                       ((funct3 == 3'b001) && !zero);

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign adr_src   = r_adr_src;
    assign reg_we    = r_reg_we;
    assign alu_src_a = r_alu_src_a;
    assign alu_src_b = r_alu_src_b;
    assign res_src   = r_res_src;
    assign alu_ctrl  = r_alu_ctrl;
    assign imm_src   = r_imm_src;
    assign ir_we     = r_in_fetch && mem_ready;
    assign pc_we     = (r_in_fetch && mem_ready) || r_in_jal || (r_in_branch && w_br_take);

`ifdef RV_ILLEGAL_TRAP_EN
    assign illegal   = r_illegal;
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-cycle expected control vectors are queued with
// their stimulus, then driven and compared cycle by cycle.
// Honours RV_ILLEGAL_TRAP_EN for the illegal-instruction scenario.

`timescale 1ns/1ps

module tb_mc_controller;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_SLL  = 4'd2;
    localparam logic [3:0] A_SLT  = 4'd3;
    localparam logic [3:0] A_SRL  = 4'd6;
    localparam logic [3:0] A_SRA  = 4'd7;
    localparam logic [3:0] A_AND  = 4'd9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_valid, mem_we, adr_src, ir_we, pc_we, reg_we, illegal;
    logic [1:0] alu_src_a, alu_src_b, res_src;
    logic [3:0] alu_ctrl;
    logic [2:0] imm_src;

    logic [19:0] w_obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic        rst;
        logic        rdy;
        logic        z;
        logic        chk;
        logic [19:0] v;
    } ent_t;

    ent_t sb[$];

    mc_controller dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .adr_src   (adr_src),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .res_src   (res_src),
        .alu_ctrl  (alu_ctrl),
        .imm_src   (imm_src),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    assign w_obs = {mem_valid, mem_we, adr_src, ir_we, pc_we, reg_we,
                    alu_src_a, alu_src_b, res_src, alu_ctrl, imm_src, illegal};

    // Expected output vectors, one per state, taken from the state output table.
    function automatic logic [19:0] ev(input logic mv, input logic mwe, input logic adr,
                                       input logic irw, input logic pcw, input logic rgw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic [3:0] alu,
                                       input logic [2:0] imm, input logic ill);
        return {mv, mwe, adr, irw, pcw, rgw, a, b, res, alu, imm, ill};
    endfunction

    function automatic logic [19:0] e_idle();
        return '0;
    endfunction
    function automatic logic [19:0] e_fetch(input logic r);
        return ev(1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b10, A_ADD, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_decode();
        return ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, A_ADD, 3'b010, 0);
    endfunction
    function automatic logic [19:0] e_memadr(input logic sw);
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, A_ADD, sw ? 3'b001 : 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_memrd();
        return ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_memwr();
        return ev(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_memwb();
        return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, A_ADD, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_execr(input logic [3:0] alu);
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, alu, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_execi(input logic [3:0] alu);
        return ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, alu, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_aluwb();
        return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_branch(input logic take);
        return ev(0, 0, 0, 0, take, 0, 2'b10, 2'b00, 2'b00, A_SUB, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_jal();
        return ev(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, A_ADD, 3'b000, 0);
    endfunction
    function automatic logic [19:0] e_lui();
        return ev(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, A_ADD, 3'b100, 0);
    endfunction
    function automatic logic [19:0] e_trap();
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, A_ADD, 3'b000, 1);
    endfunction

    task automatic push(input string tag, input logic r, input logic rdy, input logic z,
                        input logic chk, input logic [19:0] v);
        ent_t e;
        e.tag = tag;
        e.rst = r;
        e.rdy = rdy;
        e.z   = z;
        e.chk = chk;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic set_ir(input logic [31:0] ir);
        op       = ir[6:0];
        funct3   = ir[14:12];
        funct7b5 = ir[30];
    endtask

    task automatic test_reset();
        set_ir(32'h00000013);
        push("rst0", 1, 1, 0, 0, e_idle());
        push("rst_held", 1, 1, 0, 1, e_idle());
        push("idle", 0, 1, 0, 1, e_idle());
        push("fetch_wait", 0, 0, 0, 1, e_fetch(0));
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL reset/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_alu_r();
        logic [31:0] irs [5] = '{32'h002081B3, 32'h40208033, 32'h00209033,
                                 32'h4020D033, 32'h0020F033};
        logic [3:0]  alus[5] = '{A_ADD, A_SUB, A_SLL, A_SRA, A_AND};
        for (int i = 0; i < 5; i++) begin
            set_ir(irs[i]);
            push("r_fetch", 0, 1, 0, 1, e_fetch(1));
            push("r_decode", 0, 1, 0, 1, e_decode());
            push("r_exec", 0, 1, 0, 1, e_execr(alus[i]));
            push("r_wb", 0, 1, 0, 1, e_aluwb());
            while (sb.size() > 0) begin
                ent_t e = sb.pop_front();
                @(negedge clk);
                rst = e.rst; mem_ready = e.rdy; zero = e.z;
                #1;
                if (e.chk) begin
                    n_tests++;
                    if (w_obs !== e.v) begin
                        n_fail++;
                        $display("FAIL alu_r[%0d]/%s: got %05h expected %05h", i, e.tag, w_obs, e.v);
                    end
                end
            end
        end
    endtask

    task automatic test_alu_i();
        logic [31:0] irs [4] = '{32'h4020D093, 32'h40008093, 32'h0020A093, 32'h0020D093};
        logic [3:0]  alus[4] = '{A_SRA, A_ADD, A_SLT, A_SRL};
        for (int i = 0; i < 4; i++) begin
            set_ir(irs[i]);
            push("i_fetch", 0, 1, 0, 1, e_fetch(1));
            push("i_decode", 0, 1, 0, 1, e_decode());
            push("i_exec", 0, 1, 0, 1, e_execi(alus[i]));
            push("i_wb", 0, 1, 0, 1, e_aluwb());
            while (sb.size() > 0) begin
                ent_t e = sb.pop_front();
                @(negedge clk);
                rst = e.rst; mem_ready = e.rdy; zero = e.z;
                #1;
                if (e.chk) begin
                    n_tests++;
                    if (w_obs !== e.v) begin
                        n_fail++;
                        $display("FAIL alu_i[%0d]/%s: got %05h expected %05h", i, e.tag, w_obs, e.v);
                    end
                end
            end
        end
    endtask

    task automatic test_load_store();
        set_ir(32'h0000A183);
        push("lw_fetch", 0, 1, 0, 1, e_fetch(1));
        push("lw_decode", 0, 1, 0, 1, e_decode());
        push("lw_memadr", 0, 1, 0, 1, e_memadr(0));
        for (int i = 0; i < 3; i++) push("lw_memrd_wait", 0, 0, 0, 1, e_memrd());
        push("lw_memrd_done", 0, 1, 0, 1, e_memrd());
        push("lw_memwb", 0, 1, 0, 1, e_memwb());
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL load/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
        set_ir(32'h0020A023);
        push("sw_fetch_wait", 0, 0, 0, 1, e_fetch(0));
        push("sw_fetch", 0, 1, 0, 1, e_fetch(1));
        push("sw_decode", 0, 1, 0, 1, e_decode());
        push("sw_memadr", 0, 1, 0, 1, e_memadr(1));
        push("sw_memwr_wait", 0, 0, 0, 1, e_memwr());
        push("sw_memwr_done", 0, 1, 0, 1, e_memwr());
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL store/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_branch();
        // {IR, zero, taken}
        logic [31:0] irs [4] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
        logic        zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_ir(irs[i]);
            push("br_fetch", 0, 1, 0, 1, e_fetch(1));
            push("br_decode", 0, 1, 0, 1, e_decode());
            push("br_exec", 0, 1, zs[i], 1, e_branch(tk[i]));
            while (sb.size() > 0) begin
                ent_t e = sb.pop_front();
                @(negedge clk);
                rst = e.rst; mem_ready = e.rdy; zero = e.z;
                #1;
                if (e.chk) begin
                    n_tests++;
                    if (w_obs !== e.v) begin
                        n_fail++;
                        $display("FAIL branch[%0d]/%s: got %05h expected %05h", i, e.tag, w_obs, e.v);
                    end
                end
            end
        end
    endtask

    task automatic test_jal_lui();
        set_ir(32'h008000EF);
        push("jal_fetch", 0, 1, 0, 1, e_fetch(1));
        push("jal_decode", 0, 1, 0, 1, e_decode());
        push("jal_exec", 0, 1, 0, 1, e_jal());
        push("jal_wb", 0, 1, 0, 1, e_aluwb());
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL jal/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
        set_ir(32'h123450B7);
        push("lui_fetch", 0, 1, 0, 1, e_fetch(1));
        push("lui_decode", 0, 1, 0, 1, e_decode());
        push("lui_exec", 0, 1, 0, 1, e_lui());
        push("lui_wb", 0, 1, 0, 1, e_aluwb());
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL lui/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_illegal();
        set_ir(32'h0000007F);
        push("ill_fetch", 0, 1, 0, 1, e_fetch(1));
        push("ill_decode", 0, 1, 0, 1, e_decode());
`ifdef RV_ILLEGAL_TRAP_EN
        push("ill_trap0", 0, 1, 0, 1, e_trap());
        push("ill_trap1", 0, 1, 0, 1, e_trap());
        push("ill_trap_rst", 1, 1, 0, 1, e_trap());
        push("ill_idle", 0, 1, 0, 1, e_idle());
`else
        push("ill_nop_fetch", 0, 0, 0, 1, e_fetch(0));
`endif
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL illegal/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        set_ir(32'h0000A183);
        push("mid_fetch", 0, 1, 0, 1, e_fetch(1));
        push("mid_decode", 0, 1, 0, 1, e_decode());
        push("mid_memadr", 0, 1, 0, 1, e_memadr(0));
        push("mid_memrd_wait", 0, 0, 0, 1, e_memrd());
        push("mid_memrd_rst", 1, 0, 0, 1, e_memrd());
        push("mid_idle", 0, 0, 0, 1, e_idle());
        push("mid_fetch_after", 0, 0, 0, 1, e_fetch(0));
        while (sb.size() > 0) begin
            ent_t e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; zero = e.z;
            #1;
            if (e.chk) begin
                n_tests++;
                if (w_obs !== e.v) begin
                    n_fail++;
                    $display("FAIL reset_mid/%s: got %05h expected %05h", e.tag, w_obs, e.v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_alu_i();
        test_load_store();
        test_branch();
        test_jal_lui();
        test_illegal();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
